sd_req_arbiter: RTL and testbench

Serialises block-device requests from the three virtual-disk clients onto the hps_io SD channels: floppy drive 1 (VD0), the HDD controller (VD1) and floppy drive 2 (VD2). At most one SD transaction is outstanding at any time. Clients are granted round-robin. Each transaction is tracked through the hps_io ack handshake and guarded by a timeout. The block sits between the floppy_track instances / HDD sequencer and hps_io, and exports a CPU wait hint for HDD transfers.

---
 rtl/sd_req_arbiter_if.sv | 33 +++
 rtl/sd_req_arbiter.sv | 132 +++++++++++++
 tb/tb_sd_req_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_req_arbiter_if.sv
// sd_req_arbiter_if: bundles the virtual-disk client request/status lines and the hps_io SD
// channel lines that pass through sd_req_arbiter.
//   cli_rd/cli_wr   level requests, bit n = VD n (0 = floppy 1, 1 = HDD, 2 = floppy 2)
//   cli_done        one-cycle completion pulse per client
//   cli_err         one-cycle timeout pulse per client
//   cli_busy        high while the client holds the grant
//   sd_rd/sd_wr     requests towards hps_io, at most one bit set
//   sd_ack          ack from hps_io
//   hdd_wait        CPU wait hint while VD1 holds the grant
//   active          any grant held (disk LED)
// master: clients + hps_io side. slave: the arbiter.
interface sd_req_arbiter_if;
  logic [2:0] cli_rd;
  logic [2:0] cli_wr;
  logic [2:0] cli_done;
  logic [2:0] cli_err;
  logic [2:0] cli_busy;
  logic [2:0] sd_rd;
  logic [2:0] sd_wr;
  logic [2:0] sd_ack;
  logic       hdd_wait;
  logic       active;

  modport master (
    output cli_rd, cli_wr, sd_ack,
    input  cli_done, cli_err, cli_busy, sd_rd, sd_wr, hdd_wait, active
  );

  modport slave (
    input  cli_rd, cli_wr, sd_ack,
    output cli_done, cli_err, cli_busy, sd_rd, sd_wr, hdd_wait, active
  );
endinterface

// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter: serialises block-device requests from three virtual-disk clients onto the
// hps_io SD channels. One transaction at a time, round-robin grant, ack-handshake tracking
// and a request-to-ack timeout.
//   clk_sys   system clock, all state on its rising edge
//   reset_n   asynchronous active-low reset
//   bus       sd_req_arbiter_if.slave (client requests/status and hps_io SD lines)
//   TIMEOUT   clk_sys cycles from request to ack rise before giving up; 0 disables
module sd_req_arbiter #(
  parameter logic [23:0] TIMEOUT = 24'd14_000_000
) (
  input logic              clk_sys,
  input logic              reset_n,
  sd_req_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StRelease} state_e;

  state_e      state_q;
  logic [1:0]  grant_q;
  logic [1:0]  last_q;
  logic        op_q;      // 1 = write
  logic [23:0] timer_q;
  logic [2:0]  old_ack_q;
  logic [2:0]  busy_q;
  logic [2:0]  rd_q;
  logic [2:0]  wr_q;
  logic [2:0]  done_q;
  logic [2:0]  err_q;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  logic [2:0] pend;
  logic [1:0] cand1, cand2, next_g;
  logic [2:0] next_oh, grant_oh;
  logic       ack_rise, ack_fall, timeout_hit;

  assign pend  = bus.cli_rd | bus.cli_wr;
  assign cand1 = inc3(last_q);
  assign cand2 = inc3(cand1);

  // Search starts just after the last served client; the last one itself comes third.
  always_comb begin
    next_g = last_q;
    if (pend[cand1]) begin
      next_g = cand1;
    end else if (pend[cand2]) begin
      next_g = cand2;
    end
  end

  assign next_oh  = 3'b001 << next_g;
  assign grant_oh = 3'b001 << grant_q;

  // Only the granted channel's ack matters; the others are ignored.
  assign ack_rise    = bus.sd_ack[grant_q] & ~old_ack_q[grant_q];
  assign ack_fall    = ~bus.sd_ack[grant_q] & old_ack_q[grant_q];
  assign timeout_hit = (TIMEOUT != 24'd0) && (timer_q == TIMEOUT - 24'd1);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      grant_q   <= 2'd0;
      last_q    <= 2'd2;
      op_q      <= 1'b0;
      timer_q   <= 24'd0;
      old_ack_q <= 3'b000;
      busy_q    <= 3'b000;
      rd_q      <= 3'b000;
      wr_q      <= 3'b000;
      done_q    <= 3'b000;
      err_q     <= 3'b000;
    end else begin
      old_ack_q <= bus.sd_ack;
      done_q    <= 3'b000;
      err_q     <= 3'b000;
      unique case (state_q)
        StIdle: begin
          if (pend != 3'b000) begin
            grant_q <= next_g;
            op_q    <= bus.cli_wr[next_g];
            busy_q  <= next_oh;
            timer_q <= 24'd0;
            // Write wins when a client raises both lines.
            if (bus.cli_wr[next_g]) begin
              wr_q <= next_oh;
            end else begin
              rd_q <= next_oh;
            end
            state_q <= StReq;
          end
        end
        StReq: begin
          if (ack_rise) begin
            rd_q    <= 3'b000;
            wr_q    <= 3'b000;
            state_q <= StXfer;
          end else if (timeout_hit) begin
            rd_q    <= 3'b000;
            wr_q    <= 3'b000;
            err_q   <= grant_oh;
            state_q <= StRelease;
          end else begin
            timer_q <= timer_q + 24'd1;
          end
        end
        StXfer: begin
          if (ack_fall) begin
            done_q  <= grant_oh;
            state_q <= StRelease;
          end
        end
        StRelease: begin
          busy_q  <= 3'b000;
          last_q  <= grant_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cli_busy = busy_q;
  assign bus.cli_done = done_q;
  assign bus.cli_err  = err_q;
  assign bus.sd_rd    = rd_q;
  assign bus.sd_wr    = wr_q;
  assign bus.hdd_wait = busy_q[1];
  assign bus.active   = |busy_q;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Scoreboard bench for sd_req_arbiter: the stimulus side predicts each transaction (client,
// op, outcome, ack timing) and queues it; a monitor pops one record per grant and checks the
// per-cycle outputs against it.
module tb_sd_req_arbiter;

  localparam logic [23:0] TMO = 24'd16;
  localparam int TMO_I = 16;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  sd_req_arbiter_if bus ();

  sd_req_arbiter #(
    .TIMEOUT(TMO)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int g;
    bit wr;
    bit err;
    int d;  // ack rises d cycles after the first sd_rd/sd_wr cycle
    int h;  // ack high time in cycles
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   model_last = 2;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin: first pending client after the last one served, wrapping over three.
  function automatic int rr_pick(input int last, input logic [2:0] p);
    int c;
    for (int i = 1; i <= 3; i++) begin
      c = (last + i) % 3;
      if (p[c]) return c;
    end
    return -1;
  endfunction

  // Monitor: one scoreboard record per grant, checked cycle by cycle.
  initial begin : monitor
    txn_t       cur;
    int         idx;
    int         sd_len;
    int         last;
    bit         in_txn;
    bit         post;
    logic [2:0] oh;
    in_txn = 1'b0;
    post   = 1'b0;
    idx    = 0;
    sd_len = 0;
    last   = 0;
    forever begin
      @(negedge clk_sys);
      if (!mon_en) begin
        in_txn = 1'b0;
        post   = 1'b0;
        continue;
      end
      if (post) begin
        check("busy_after_release", int'(bus.cli_busy), 0);
        check("sd_after_release", int'(bus.sd_rd | bus.sd_wr), 0);
        post = 1'b0;
      end else if (!in_txn) begin
        if (bus.cli_busy != 3'b000) begin
          if (exp_q.size() == 0) begin
            check("unexpected_grant", int'(bus.cli_busy), 0);
          end else begin
            cur    = exp_q.pop_front();
            in_txn = 1'b1;
            idx    = 0;
            sd_len = cur.err ? TMO_I : cur.d + 1;
            last   = cur.err ? TMO_I : cur.d + cur.h + 1;
          end
        end else begin
          check("idle_outputs", int'({bus.sd_rd, bus.sd_wr, bus.cli_done, bus.cli_err,
                                      bus.hdd_wait, bus.active}), 0);
        end
      end
      if (in_txn) begin
        oh = 3'b001 << cur.g;
        check("cli_busy", int'(bus.cli_busy), int'(oh));
        check("hdd_wait", int'(bus.hdd_wait), int'(cur.g == 1));
        check("active", int'(bus.active), 1);
        check("sd_rd", int'(bus.sd_rd), (!cur.wr && idx < sd_len) ? int'(oh) : 0);
        check("sd_wr", int'(bus.sd_wr), (cur.wr && idx < sd_len) ? int'(oh) : 0);
        check("cli_done", int'(bus.cli_done), (!cur.err && idx == last) ? int'(oh) : 0);
        check("cli_err", int'(bus.cli_err), (cur.err && idx == last) ? int'(oh) : 0);
        if (idx == last) begin
          in_txn = 1'b0;
          post   = 1'b1;
        end
        idx++;
      end
    end
  end

  // Hold requests rd/wr for k transactions, acting as hps_io for each grant.
  // fd/fh/fto < 0 pick random ack delay / ack length / timeout choice.
  task automatic run_burst(input logic [2:0] rd, input logic [2:0] wr, input int k,
                           input int fd, input int fh, input int fto);
    logic [2:0] p;
    txn_t       t;
    int         waited;
    int         gobs;
    int         stray;
    bit         seen;
    p = rd | wr;
    @(negedge clk_sys);
    bus.cli_rd = rd;
    bus.cli_wr = wr;
    for (int n = 0; n < k; n++) begin
      t.g   = rr_pick(model_last, p);
      t.wr  = wr[t.g];
      t.err = (fto >= 0) ? (fto != 0) : ($urandom_range(0, 4) == 0);
      t.d   = (fd >= 0) ? fd : int'($urandom_range(0, 12));
      t.h   = (fh >= 0) ? fh : int'($urandom_range(1, 8));
      exp_q.push_back(t);
      model_last = t.g;
      waited = 0;
      do begin
        @(negedge clk_sys);
        waited++;
      end while (bus.cli_busy == 3'b000 && waited < 8);
      check("grant_latency", waited, (n == 0) ? 1 : 2);
      if (bus.cli_busy == 3'b000) begin
        bus.cli_rd = 3'b000;
        bus.cli_wr = 3'b000;
        return;
      end
      gobs = t.g;
      for (int b = 0; b < 3; b++) begin
        if (bus.sd_rd[b] | bus.sd_wr[b]) gobs = b;
      end
      stray = (gobs + 1 + int'($urandom_range(0, 1))) % 3;
      seen  = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
        if (!t.err) begin
          if (i == t.d) bus.sd_ack[gobs] = 1'b1;
          if (i == t.d + t.h) bus.sd_ack[gobs] = 1'b0;
        end
        if ($urandom_range(0, 2) == 0) bus.sd_ack[stray] = ~bus.sd_ack[stray];
        @(negedge clk_sys);
        if ((bus.cli_done | bus.cli_err) != 3'b000) begin
          seen = 1'b1;
          if (n == k - 1) begin
            bus.cli_rd = 3'b000;
            bus.cli_wr = 3'b000;
          end
        end
      end
      check("completion_seen", int'(seen), 1);
      bus.sd_ack = 3'b000;
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [2:0] rd;
    logic [2:0] wr;
    int         waited;
    bus.cli_rd = 3'b000;
    bus.cli_wr = 3'b000;
    bus.sd_ack = 3'b000;
    reset_n    = 1'b0;
    #2;
    check("reset_busy", int'(bus.cli_busy), 0);
    check("reset_sd", int'({bus.sd_rd, bus.sd_wr}), 0);
    check("reset_pulses", int'({bus.cli_done, bus.cli_err}), 0);
    check("reset_flags", int'({bus.hdd_wait, bus.active}), 0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Round-robin from reset: 0,1,2,0.
    run_burst(3'b111, 3'b000, 4, -1, -1, 0);
    // Single read, ack late and long.
    run_burst(3'b001, 3'b000, 1, 4, 20, 0);
    // Read and write raised together: write wins.
    run_burst(3'b010, 3'b010, 1, -1, -1, 0);
    // No ack: timeout on a write.
    run_burst(3'b000, 3'b100, 1, 0, 1, 1);

    repeat (25) begin
      rd = 3'($urandom);
      wr = 3'($urandom);
      if ((rd | wr) == 3'b000) rd = 3'b001;
      run_burst(rd, wr, int'($urandom_range(1, 3)), -1, -1, -1);
    end

    // Asynchronous reset in the middle of a VD1 transfer.
    @(negedge clk_sys);
    mon_en = 1'b0;
    check("queue_drained", exp_q.size(), 0);
    bus.cli_rd = 3'b010;
    waited = 0;
    do begin
      @(negedge clk_sys);
      waited++;
    end while (bus.sd_rd[1] == 1'b0 && waited < 8);
    check("reset_txn_granted", int'(bus.sd_rd), 3'b010);
    bus.sd_ack[1] = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("busy_before_reset", int'(bus.cli_busy), 3'b010);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_busy", int'(bus.cli_busy), 0);
    check("async_reset_sd", int'({bus.sd_rd, bus.sd_wr}), 0);
    check("async_reset_pulses", int'({bus.cli_done, bus.cli_err}), 0);
    check("async_reset_flags", int'({bus.hdd_wait, bus.active}), 0);
    bus.sd_ack = 3'b000;
    bus.cli_rd = 3'b000;
    repeat (2) @(negedge clk_sys);
    reset_n    = 1'b1;
    model_last = 2;
    mon_en     = 1'b1;
    // last_grant back at 2, so VD0 comes first.
    run_burst(3'b011, 3'b000, 1, -1, -1, 0);
    repeat (4) @(negedge clk_sys);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
